// File: rtl/hash_feed_pkg.sv
// Shared types and defaults for the hash message feeder slice.
package hash_feed_pkg;

    localparam int DATA_W_DFLT   = 8;
    localparam int DIGEST_W_DFLT = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        FEED,
        EOF,
        WAIT_H,
        DONE
    } feed_state_t;

    typedef struct packed {
        logic                   eom;
        logic [DATA_W_DFLT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/hash_feed_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage registers.
module hash_feed_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// Streams buffered host beats to the hash core, closes the message and captures the digest.
module hash_msg_feeder
    import hash_feed_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int DIGEST_W   = DIGEST_W_DFLT,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                msg_start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_eom,
    output logic                F_start,
    output logic                F_dr,
    input  logic                F_rtr,
    output logic [DATA_W-1:0]   M_data,
    output logic                End_of_File,
    input  logic                H_ready,
    input  logic [DIGEST_W-1:0] H_digest,
    output logic [DIGEST_W-1:0] hash_out,
    output logic                hash_valid,
    input  logic                hash_ack,
    output logic                busy,
    output logic                timeout_err
);

    feed_state_t         state, state_nxt;
    logic [DATA_W:0]     head;
    logic                full, empty, flush, push, pop;
    logic                eom_pushed;
    logic                h_ready_d;
    logic                h_rise;
    logic                wait_done;
    logic [15:0]         wait_cnt;
    logic                timeout_q;
    logic [DIGEST_W-1:0] hash_q;

    hash_feed_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({in_eom, in_data}),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign h_rise    = H_ready & ~h_ready_d;
    assign wait_done = (wait_cnt == 16'(TIMEOUT - 1));
    assign push      = in_valid & in_ready;

    always_comb begin
        state_nxt   = state;
        flush       = 1'b0;
        pop         = 1'b0;
        F_start     = 1'b0;
        F_dr        = 1'b0;
        End_of_File = 1'b0;
        in_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (msg_start) begin
                    flush     = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                F_start   = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                in_ready = ~full & ~eom_pushed;
                if (!empty) begin
                    // The marker is consumed internally and never offered to the core.
                    if (head[DATA_W]) begin
                        pop       = 1'b1;
                        state_nxt = EOF;
                    end else begin
                        F_dr = 1'b1;
                        pop  = F_rtr;
                    end
                end
            end
            EOF: begin
                End_of_File = 1'b1;
                state_nxt   = WAIT_H;
            end
            WAIT_H: begin
                if (h_rise)         state_nxt = DONE;
                else if (wait_done) state_nxt = IDLE;
            end
            DONE: begin
                if (hash_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign M_data      = F_dr ? head[DATA_W-1:0] : '0;
    assign busy        = (state != IDLE);
    assign hash_valid  = (state == DONE);
    assign hash_out    = hash_q;
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            h_ready_d  <= 1'b0;
            eom_pushed <= 1'b0;
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
            hash_q     <= '0;
        end else begin
            state     <= state_nxt;
            h_ready_d <= H_ready;
            if (state == IDLE && msg_start) eom_pushed <= 1'b0;
            else if (push && in_eom)        eom_pushed <= 1'b1;
            if (state == EOF)         wait_cnt <= '0;
            else if (state == WAIT_H) wait_cnt <= wait_cnt + 1'b1;
            if (state == IDLE && msg_start)                   timeout_q <= 1'b0;
            else if (state == WAIT_H && !h_rise && wait_done) timeout_q <= 1'b1;
            if (state == WAIT_H && h_rise) hash_q <= H_digest;
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed-plus-random bench for hash_msg_feeder with a byte-queue reference model.
module tb_hash_msg_feeder;

    localparam int DATA_W     = 8;
    localparam int DIGEST_W   = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                msg_start = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = '0;
    logic                in_eom = 1'b0;
    logic                F_start;
    logic                F_dr;
    logic                F_rtr = 1'b0;
    logic [DATA_W-1:0]   M_data;
    logic                End_of_File;
    logic                H_ready = 1'b0;
    logic [DIGEST_W-1:0] H_digest = '0;
    logic [DIGEST_W-1:0] hash_out;
    logic                hash_valid;
    logic                hash_ack = 1'b0;
    logic                busy;
    logic                timeout_err;

    hash_msg_feeder #(
        .DATA_W     (DATA_W),
        .DIGEST_W   (DIGEST_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_start   (msg_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_eom      (in_eom),
        .F_start     (F_start),
        .F_dr        (F_dr),
        .F_rtr       (F_rtr),
        .M_data      (M_data),
        .End_of_File (End_of_File),
        .H_ready     (H_ready),
        .H_digest    (H_digest),
        .hash_out    (hash_out),
        .hash_valid  (hash_valid),
        .hash_ack    (hash_ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx[$];
    logic [7:0]  exp_q[$];
    int          idx;
    bit          eom_sent;
    int          rx_cnt;
    int          fdr_seen;
    int          eof_gap;
    logic [63:0] last_dig;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_f_start"}, F_start, 0);
        check({tag, "_f_dr"}, F_dr, 0);
        check({tag, "_eof"}, End_of_File, 0);
        check({tag, "_hash_valid"}, hash_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_m_data"}, M_data, 0);
        check({tag, "_hash_out"}, hash_out, 0);
    endtask

    task automatic start_msg();
        msg_start = 1'b1;
        step();
        msg_start = 1'b0;
        check("f_start", F_start, 1);
        check("busy_start", busy, 1);
        check("timeout_err_cleared", timeout_err, 0);
        step();
        check("f_start_once", F_start, 0);
        idx = 0; eom_sent = 0; rx_cnt = 0; fdr_seen = 0;
        exp_q.delete();
    endtask

    // mode 0: F_rtr=1; mode 1: toggle each cycle; mode 2: random. Returns in WAIT_H.
    task automatic stream(input int mode, input bit poke);
        bit         stall = 0;
        logic [7:0] hold = '0;
        bit         done = 0;
        for (int cyc = 1; cyc < 2000 && !done; cyc++) begin
            if (stall) begin
                check("stall_fdr", F_dr, 1);
                check("stall_data", M_data, hold);
            end
            check("no_stray_f_start", F_start, 0);
            if (End_of_File) begin
                eof_gap  = cyc;
                in_valid = 0;
                F_rtr    = 0;
                done     = 1;
            end else begin
                if (idx < tx.size()) begin
                    in_valid = 1; in_eom = 0; in_data = tx[idx];
                end else if (!eom_sent) begin
                    in_valid = 1; in_eom = 1; in_data = 8'($urandom);
                end else begin
                    in_valid = 0; in_eom = 0;
                end
                if (in_valid && in_ready) begin
                    if (in_eom) eom_sent = 1;
                    else begin exp_q.push_back(in_data); idx++; end
                end
                F_rtr     = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
                msg_start = poke && (cyc == 3);
                if (F_dr) fdr_seen++;
                if (F_dr && F_rtr) begin
                    rx_cnt++;
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("beat_data", M_data, exp_q.pop_front());
                end
                stall = F_dr && !F_rtr;
                hold  = M_data;
                step();
            end
        end
        msg_start = 0;
        in_valid  = 0;
        in_eom    = 0;
        check("eof_seen", done, 1);
        check("beat_count", rx_cnt, tx.size());
        check("model_drained", exp_q.size(), 0);
        step();
        check("eof_once", End_of_File, 0);
    endtask

    task automatic capture(input logic [63:0] d);
        H_digest = d;
        H_ready  = 1;
        step();
        check("hash_valid", hash_valid, 1);
        check("hash_out", hash_out, d);
        step();
        check("hash_valid_held", hash_valid, 1);
        hash_ack = 1;
        step();
        hash_ack = 0;
        H_ready  = 0;
        check("hash_valid_drop", hash_valid, 0);
        check("busy_idle", busy, 0);
        last_dig = d;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        #3 rst_n = 1;
        step();
        check_all_zero("rst_post");

        // 1: abc message
        tx = '{8'h61, 8'h62, 8'h63};
        start_msg();
        stream(0, 0);
        capture(64'hDEADBEEF_01234567);

        // 2: F_rtr toggling, stray msg_start mid-stream
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        start_msg();
        stream(1, 1);
        capture({$urandom, $urandom});

        // 3: fill to full with F_rtr=0, then drain
        tx.delete();
        for (int i = 0; i < 9; i++) tx.push_back(8'($urandom));
        start_msg();
        F_rtr = 0;
        for (int i = 0; i < 8; i++) begin
            check("fill_in_ready", in_ready, 1);
            check("fill_latency_fdr", F_dr, i > 0);
            in_valid = 1; in_eom = 0; in_data = tx[i];
            exp_q.push_back(tx[i]); idx++;
            step();
        end
        in_data = tx[8];
        check("full_in_ready", in_ready, 0);
        step();
        check("full_in_ready2", in_ready, 0);
        check("full_fdr", F_dr, 1);
        check("full_head", M_data, tx[0]);
        F_rtr = 1;
        void'(exp_q.pop_front());
        rx_cnt++;
        step();
        check("ready_after_pop", in_ready, 1);
        stream(0, 0);
        capture({$urandom, $urandom});

        // 4: empty message; hash_ack outside DONE ignored
        tx.delete();
        start_msg();
        stream(0, 0);
        check("empty_no_fdr", fdr_seen, 0);
        check("empty_eof_gap", eof_gap >= 2, 1);
        hash_ack = 1;
        step(); step();
        hash_ack = 0;
        check("stray_ack_busy", busy, 1);
        check("stray_ack_hv", hash_valid, 0);
        capture({$urandom, $urandom});

        // 5: stale H_ready -> timeout
        tx = '{8'h11, 8'h22};
        start_msg();
        H_ready  = 1;
        H_digest = 64'h0BAD_0BAD_0BAD_0BAD;
        stream(0, 0);
        begin
            int cnt = 0;
            int hv  = 0;
            while (busy && cnt < 4 * TIMEOUT) begin
                step();
                cnt++;
                if (hash_valid) hv++;
            end
            check("timeout_cycles", cnt, TIMEOUT);
            check("timeout_no_capture", hv, 0);
        end
        check("timeout_err_set", timeout_err, 1);
        check("timeout_hash_kept", hash_out, last_dig);
        H_ready = 0;
        step();

        // 6: reset mid-FEED with 3 beats buffered
        start_msg();
        F_rtr = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_eom = 0; in_data = 8'($urandom_range(1, 255));
            step();
        end
        in_valid = 0;
        check("pre_rst_fdr", F_dr, 1);
        rst_n = 0;
        #2;
        check_all_zero("async_rst");
        #3 rst_n = 1;
        step();
        tx.delete();
        for (int i = 0; i < 12; i++) tx.push_back(8'($urandom));
        start_msg();
        stream(2, 0);
        capture({$urandom, $urandom});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
